// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits MSB first, optional even parity, stop(0).
// Delivers good words into a valid/ready holding register; flags parity, framing and overrun.
module serial_frame_rx #(
  parameter int WIDTH     = 4,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_en,
  input  logic             sdi,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic             par, par_nxt;
  logic             perr, ferr, stop_edge, good, load, drop_full;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    par_nxt   = par;
    perr      = 1'b0;
    ferr      = 1'b0;
    stop_edge = 1'b0;
    if (bit_en) begin
      case (state)
        IDLE: if (sdi) begin
          state_nxt = DATA;
          cnt_nxt   = '0;
        end
        DATA: begin
          shreg_nxt = {shreg[WIDTH-2:0], sdi};
          cnt_nxt   = cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state_nxt = PARITY_EN ? PARITY : STOP;
        end
        PARITY: begin
          par_nxt   = sdi;
          state_nxt = STOP;
        end
        STOP: begin
          stop_edge = 1'b1;
          perr      = PARITY_EN && ((^shreg) != par);
          ferr      = sdi;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A consumer taking the old word on the stop edge frees the register for the new one.
  assign good      = stop_edge && !perr && !ferr;
  assign load      = good && (!m_valid || m_ready);
  assign drop_full = good && m_valid && !m_ready;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      shreg      <= shreg_nxt;
      par        <= par_nxt;
      parity_err <= perr;
      frame_err  <= ferr;
      overrun    <= drop_full;
      if (load) begin
        m_data  <= shreg;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx (WIDTH=4, PARITY_EN=1): a frame-level model collects the
// sampled bits of each frame and judges it when the stop bit has been sampled.
module tb_serial_frame_rx;

  localparam int W   = 4;
  localparam int FL  = W + 2;  // bits after the start bit: data, parity, stop

  logic         clk = 1'b0;
  logic         reset, bit_en, sdi, m_ready;
  logic [W-1:0] m_data;
  logic         m_valid, busy, parity_err, frame_err, overrun;

  serial_frame_rx #(.WIDTH(W), .PARITY_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .bit_en(bit_en), .sdi(sdi),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // frame-level reference state
  int           fl;
  logic         bq[$];
  logic         e_valid, e_perr, e_ferr, e_ovr;
  logic [W-1:0] e_data;
  int           loads;

  function automatic logic [6:0] mk(input logic [3:0] d, input logic pflip, input logic stop);
    return {1'b1, d, (^d) ^ pflip, stop};
  endfunction

  task automatic model_reset();
    fl = 0; bq.delete();
    e_valid = 0; e_data = '0; e_perr = 0; e_ferr = 0; e_ovr = 0;
  endtask

  // Drive one clock's inputs, advance the model over that edge, sample 1ns after it.
  task automatic tick(input logic s, input logic en, input logic rdy);
    logic         good;
    logic [W-1:0] d;
    @(negedge clk);
    sdi = s; bit_en = en; m_ready = rdy;
    e_perr = 0; e_ferr = 0; e_ovr = 0; good = 0; d = '0;
    if (en) begin
      if (fl == 0) begin
        if (s) begin fl = FL; bq.delete(); end
      end else begin
        bq.push_back(s);
        fl--;
        if (fl == 0) begin
          for (int i = 0; i < W; i++) d[W-1-i] = bq[i];
          e_perr = ((^d) != bq[W]);
          e_ferr = bq[W+1];
          good   = !e_perr && !e_ferr;
        end
      end
    end
    if (good && (!e_valid || rdy)) begin
      e_valid = 1; e_data = d; loads++;
    end else begin
      if (good) e_ovr = 1;
      if (e_valid && rdy) e_valid = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1; bit_en = 0; sdi = 0; m_ready = 0;
    model_reset();
    #12;
    checks++;
    if ({m_data, m_valid, busy, parity_err, frame_err, overrun} !== '0) begin
      fails++;
      $display("FAIL reset_state: got data=%b v=%b busy=%b pe=%b fe=%b ov=%b want all 0",
               m_data, m_valid, busy, parity_err, frame_err, overrun);
    end
    @(negedge clk); reset = 0;
  endtask

  task automatic test_basic();
    logic [6:0] f = 7'b1101000;
    int busy_cnt = 0;
    for (int i = 6; i >= -2; i--) begin
      tick(i >= 0 ? f[i] : 1'b0, 1'b1, 1'b1);
      busy_cnt += busy;
      checks++;
      if ({m_valid, busy, parity_err, frame_err, overrun} !== {e_valid, fl > 0, e_perr, e_ferr, e_ovr}) begin
        fails++;
        $display("FAIL basic_flags bit%0d: got %b want %b", i,
                 {m_valid, busy, parity_err, frame_err, overrun}, {e_valid, fl > 0, e_perr, e_ferr, e_ovr});
      end
      if (i == 0) begin
        checks++;
        if (!(m_valid === 1'b1 && m_data === 4'b1010)) begin
          fails++;
          $display("FAIL basic_word: got v=%b data=%b want v=1 data=1010", m_valid, m_data);
        end
      end
    end
    checks++;
    if (busy_cnt != 6) begin
      fails++;
      $display("FAIL basic_busy_len: got %0d want 6", busy_cnt);
    end
  endtask

  task automatic test_errors();
    for (int k = 0; k < 2; k++) begin
      logic [6:0] f = mk(4'b1011, 1'b1, k[0]);
      for (int i = 6; i >= 0; i--) begin
        tick(f[i], 1'b1, 1'b1);
        checks++;
        if ({m_valid, busy, parity_err, frame_err, overrun} !== {e_valid, fl > 0, e_perr, e_ferr, e_ovr}) begin
          fails++;
          $display("FAIL errors%0d_flags bit%0d: got %b want %b", k, i,
                   {m_valid, busy, parity_err, frame_err, overrun}, {e_valid, fl > 0, e_perr, e_ferr, e_ovr});
        end
      end
      checks++;
      if ({m_valid, parity_err, frame_err} !== {1'b0, 1'b1, k[0]}) begin
        fails++;
        $display("FAIL errors%0d_pulse: got v/pe/fe=%b want %b", k,
                 {m_valid, parity_err, frame_err}, {1'b0, 1'b1, k[0]});
      end
    end
    tick(1'b0, 1'b1, 1'b1);
    checks++;
    if ({parity_err, frame_err} !== 2'b00) begin
      fails++;
      $display("FAIL errors_selfclear: got %b want 00", {parity_err, frame_err});
    end
  endtask

  task automatic test_overrun();
    logic [13:0] f = {mk(4'b1010, 1'b0, 1'b0), mk(4'b0110, 1'b0, 1'b0)};
    for (int i = 13; i >= 0; i--) begin
      tick(f[i], 1'b1, 1'b0);
      checks++;
      if ({m_valid, busy, parity_err, frame_err, overrun} !== {e_valid, fl > 0, e_perr, e_ferr, e_ovr}) begin
        fails++;
        $display("FAIL overrun_flags bit%0d: got %b want %b", i,
                 {m_valid, busy, parity_err, frame_err, overrun}, {e_valid, fl > 0, e_perr, e_ferr, e_ovr});
      end
      if (e_valid) begin
        checks++;
        if (m_data !== e_data) begin
          fails++;
          $display("FAIL overrun_data bit%0d: got %b want %b", i, m_data, e_data);
        end
      end
    end
    checks++;
    if ({overrun, m_valid, m_data} !== {2'b11, 4'b1010}) begin
      fails++;
      $display("FAIL overrun_event: got ov/v/data=%b want 111010", {overrun, m_valid, m_data});
    end
    tick(1'b0, 1'b1, 1'b1);
    checks++;
    if ({m_valid, overrun} !== 2'b00) begin
      fails++;
      $display("FAIL overrun_drain: got v/ov=%b want 00", {m_valid, overrun});
    end
  endtask

  task automatic test_slow_strobe();
    logic [6:0] f = mk(4'b1100, 1'b0, 1'b0);
    for (int i = 6; i >= -1; i--) begin
      for (int c = 0; c < 3; c++) begin
        logic en = (c == 2);
        logic s  = en ? (i >= 0 ? f[i] : 1'b0) : 1'($urandom_range(0, 1));
        tick(s, en, 1'b1);
        checks++;
        if ({m_valid, busy, parity_err, frame_err, overrun} !== {e_valid, fl > 0, e_perr, e_ferr, e_ovr}) begin
          fails++;
          $display("FAIL slow_flags bit%0d clk%0d: got %b want %b", i, c,
                   {m_valid, busy, parity_err, frame_err, overrun}, {e_valid, fl > 0, e_perr, e_ferr, e_ovr});
        end
        if (i == 0 && en) begin
          checks++;
          if (m_data !== 4'b1100) begin
            fails++;
            $display("FAIL slow_word: got %b want 1100", m_data);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] f = mk(4'b0101, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'($urandom_range(0, 1)), 1'b1, 1'b1);
    tick(1'($urandom_range(0, 1)), 1'b1, 1'b1);
    @(negedge clk); reset = 1; #1;
    model_reset();
    checks++;
    if ({busy, m_valid} !== 2'b00) begin
      fails++;
      $display("FAIL reset_mid: got busy/v=%b want 00", {busy, m_valid});
    end
    @(negedge clk); reset = 0; bit_en = 0; sdi = 0;
    for (int i = 6; i >= 0; i--) begin
      tick(f[i], 1'b1, 1'b1);
      checks++;
      if ({m_valid, busy, parity_err, frame_err, overrun} !== {e_valid, fl > 0, e_perr, e_ferr, e_ovr}) begin
        fails++;
        $display("FAIL reset_mid_flags bit%0d: got %b want %b", i,
                 {m_valid, busy, parity_err, frame_err, overrun}, {e_valid, fl > 0, e_perr, e_ferr, e_ovr});
      end
    end
    checks++;
    if ({m_valid, m_data} !== 5'b10101) begin
      fails++;
      $display("FAIL reset_mid_word: got v/data=%b want 10101", {m_valid, m_data});
    end
  endtask

  task automatic test_idle_back_to_back();
    int l0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b1, 1'b1);
      checks++;
      if ({m_valid, busy, parity_err, frame_err, overrun} !== 5'b0) begin
        fails++;
        $display("FAIL idle cyc%0d: got %b want 00000", i, {m_valid, busy, parity_err, frame_err, overrun});
      end
    end
    l0 = loads;
    begin
      logic [13:0] f = {mk(4'($urandom), 1'b0, 1'b0), mk(4'($urandom), 1'b0, 1'b0)};
      for (int i = 13; i >= 0; i--) tick(f[i], 1'b1, 1'b1);
    end
    checks++;
    if (loads - l0 != 2 || m_valid !== 1'b1 || m_data !== e_data) begin
      fails++;
      $display("FAIL b2b_pair: got v=%b data=%b want v=1 data=%b loads=%0d", m_valid, m_data, e_data, loads - l0);
    end
    // random frames, random strobes, random consumer, random corruption
    for (int n = 0; n < 40; n++) begin
      logic [6:0] f = mk(4'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      for (int i = 6; i >= 0; i--) begin
        logic en;
        do begin
          en = ($urandom_range(0, 3) != 0);
          tick(en ? f[i] : 1'($urandom_range(0, 1)), en, 1'($urandom_range(0, 1)));
          checks++;
          if ({m_valid, busy, parity_err, frame_err, overrun} !== {e_valid, fl > 0, e_perr, e_ferr, e_ovr}) begin
            fails++;
            $display("FAIL rand_flags f%0d bit%0d: got %b want %b", n, i,
                     {m_valid, busy, parity_err, frame_err, overrun}, {e_valid, fl > 0, e_perr, e_ferr, e_ovr});
          end
          if (e_valid) begin
            checks++;
            if (m_data !== e_data) begin
              fails++;
              $display("FAIL rand_data f%0d bit%0d: got %b want %b", n, i, m_data, e_data);
            end
          end
        end while (!en);
      end
    end
  endtask

  initial begin
    loads = 0;
    test_reset();
    test_basic();
    test_errors();
    test_overrun();
    test_slow_strobe();
    test_reset_mid();
    test_idle_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
